// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared widths, FSM state and queued-write entry for the register-file writeback unit.
package rf_wb_pkg;
   localparam int DEF_XLEN = 32;
   localparam int DEF_REG_ADDR_W = 5;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} wb_state_t;
   typedef struct packed {
      logic [DEF_REG_ADDR_W-1:0] rd;
      logic [DEF_XLEN-1:0]       data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of pending writeback entries; pushes when full and pops when empty are dropped.
module wb_fifo import rf_wb_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push,
   input  wb_entry_t                    i_din,
   input  logic                         i_pop,
   output wb_entry_t                    o_dout,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   wb_entry_t      r_mem [DEPTH];
   logic [AW-1:0]  r_wp, r_rp;
   logic [CW-1:0]  r_cnt;
   logic           w_push, w_pop;
   assign o_full  = r_cnt == CW'(DEPTH);
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   assign o_dout  = r_mem[r_rp];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_din;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/regfile_writeback_unit.sv
// regfile_writeback_unit: arbitrates ALU and long-latency results onto the register-file write port,
// tracks pending long destinations and drains before halting. Optional macro WB_BYPASS_EN.
module regfile_writeback_unit import rf_wb_pkg::*; #(
   parameter int XLEN       = DEF_XLEN,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [XLEN-1:0]       alu_data,
   input  logic                  issue_valid,
   input  logic [REG_ADDR_W-1:0] issue_rd,
   input  logic                  long_valid,
   output logic                  long_ready,
   input  logic [REG_ADDR_W-1:0] long_rd,
   input  logic [XLEN-1:0]       long_data,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   input  logic                  halt_req,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [XLEN-1:0]       wb_data,
   output logic                  wb_write_enable,
   output logic                  is_drained
);
   localparam int NREG = 1 << REG_ADDR_W;
   localparam int CW   = $clog2(DEPTH+1);
   wb_state_t             r_state;
   logic                  r_drained, r_we;
   logic [REG_ADDR_W-1:0] r_rd;
   logic [XLEN-1:0]       r_data;
   logic [NREG-1:0]       r_sb;
   wb_entry_t             w_head, w_in;
   logic                  w_full, w_empty;
   logic [CW-1:0]         w_count;
   logic                  w_halted, w_hs, w_alu, w_bypass, w_fifo_push, w_pop;
   logic                  w_sel_long, w_sel_valid, w_issue, w_idle;
   logic [REG_ADDR_W-1:0] w_sel_rd;
   logic [XLEN-1:0]       w_sel_data;
   logic [NREG-1:0]       w_set, w_clr;
   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_fifo_push),
      .i_din   (w_in),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   assign w_halted   = r_state == HALTED;
   assign long_ready = !w_halted && !w_full;
   assign w_hs       = long_valid && long_ready;
   assign w_alu      = alu_valid && !w_halted;
`ifdef WB_BYPASS_EN
   assign w_bypass   = w_hs && w_empty && !w_alu;
`else
   assign w_bypass   = 1'b0;
`endif
   assign w_fifo_push = w_hs && !w_bypass;
   assign w_pop       = !w_alu && !w_empty && !w_halted;
   assign w_in        = '{rd: long_rd, data: long_data};
   assign w_sel_long  = w_pop || w_bypass;
   assign w_sel_valid = w_alu || w_sel_long;
   assign w_sel_rd    = w_alu ? alu_rd : w_bypass ? long_rd : w_pop ? w_head.rd : '0;
   assign w_sel_data  = w_alu ? alu_data : w_bypass ? long_data : w_pop ? w_head.data : '0;
   assign w_issue     = issue_valid && r_state == RUN && issue_rd != '0;
   assign w_set       = w_issue ? NREG'(1) << issue_rd : '0;
   // Pending bit drops at the edge that loads the long write, so busy is already low while it is on wb_*
   assign w_clr       = w_sel_long ? NREG'(1) << w_sel_rd : '0;
   assign w_idle      = w_count == '0 && r_sb == '0 && !r_we && !w_sel_valid && !w_hs;
   assign rs1_busy    = rs1 != '0 && r_sb[rs1];
   assign rs2_busy    = rs2 != '0 && r_sb[rs2];
   assign wb_rd           = r_rd;
   assign wb_data         = r_data;
   assign wb_write_enable = r_we;
   assign is_drained      = r_drained;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we   <= 1'b0;
         r_rd   <= '0;
         r_data <= '0;
         r_sb   <= '0;
      end else begin
         r_we   <= w_sel_valid && w_sel_rd != '0;
         r_rd   <= w_sel_rd;
         r_data <= w_sel_data;
         r_sb   <= (r_sb & ~w_clr) | w_set;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= RUN;
         r_drained <= 1'b0;
      end else begin
         r_state   <= (r_state == RUN && halt_req) ? DRAIN :
                      (r_state == DRAIN && w_idle) ? HALTED : r_state;
         r_drained <= w_halted || (r_state == DRAIN && w_idle);
      end
   end
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// tb_regfile_writeback_unit: scoreboard bench; expected writes are queued at drive time and popped on wb_write_enable.
module tb_regfile_writeback_unit;
`ifdef WB_BYPASS_EN
   localparam int LONG_LAT = 1;
`else
   localparam int LONG_LAT = 2;
`endif
   logic        clk = 1'b0, reset = 1'b1;
   logic        alu_valid, issue_valid, long_valid, long_ready, halt_req;
   logic [4:0]  alu_rd, issue_rd, long_rd, rs1, rs2, wb_rd;
   logic [31:0] alu_data, long_data, wb_data;
   logic        rs1_busy, rs2_busy, wb_write_enable, is_drained;
   typedef struct {logic [4:0] rd; logic [31:0] data; int cyc;} exp_t;
   exp_t        q[$], lq[$], m_e;
   int          cyc = 0, n_cmp = 0, n_err = 0, acc, sent, w;
   regfile_writeback_unit dut (
      .clk(clk), .reset(reset),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd),
      .long_valid(long_valid), .long_ready(long_ready), .long_rd(long_rd), .long_data(long_data),
      .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .halt_req(halt_req),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_write_enable(wb_write_enable), .is_drained(is_drained)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      issue_valid = 0; issue_rd = 0;
      long_valid = 0; long_rd = 0; long_data = 0;
      halt_req = 0;
   endtask
   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d, input int c);
      q.push_back('{rd, d, c});
   endtask
   always @(negedge clk) begin
      if (!reset && wb_write_enable) begin
         if (q.size() == 0) check_eq("spurious_wr", 64'(wb_write_enable), 64'd0);
         else begin
            m_e = q.pop_front();
            check_eq("wb_rd", 64'(wb_rd), 64'(m_e.rd));
            check_eq("wb_data", 64'(wb_data), 64'(m_e.data));
            if (m_e.cyc >= 0) check_eq("wb_cycle", 64'(cyc), 64'(m_e.cyc));
         end
      end
   end
   initial begin
      idle_inputs();
      rs1 = 0; rs2 = 0;
      repeat (3) tick();
      reset = 0;
      check_eq("rst_we", 64'(wb_write_enable), 64'd0);
      check_eq("rst_rd", 64'(wb_rd), 64'd0);
      check_eq("rst_data", 64'(wb_data), 64'd0);
      check_eq("rst_ready", 64'(long_ready), 64'd1);
      check_eq("rst_drained", 64'(is_drained), 64'd0);
      // ALU single-cycle write
      alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
      expect_wr(5, 32'h1234, cyc + 1);
      tick(); idle_inputs(); repeat (2) tick();
      check_eq("alu_one_cycle", 64'(wb_write_enable), 64'd0);
      // ALU and long result in the same cycle
      check_eq("ready_idle", 64'(long_ready), 64'd1);
      alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
      long_valid = 1; long_rd = 7; long_data = 32'hBEEF;
      expect_wr(3, 32'h33, cyc + 1);
      expect_wr(7, 32'hBEEF, cyc + 2);
      tick(); idle_inputs(); repeat (3) tick();
      // long result alone
      long_valid = 1; long_rd = 11; long_data = 32'hAAAA;
      expect_wr(11, 32'hAAAA, cyc + LONG_LAT);
      tick(); idle_inputs(); repeat (3) tick();
      // x0 results are consumed without a write
      long_valid = 1; long_rd = 0; long_data = 32'hDEAD;
      tick(); idle_inputs();
      alu_valid = 1; alu_rd = 0; alu_data = 32'h5;
      tick(); idle_inputs(); repeat (3) tick();
      check_eq("x0_ready", 64'(long_ready), 64'd1);
      // fill the FIFO behind a busy ALU
      acc = 0; sent = 0;
      for (int i = 0; i < 6; i++) begin
         alu_valid = 1; alu_rd = 5'(16 + i); alu_data = 32'h500 + 32'(i);
         expect_wr(alu_rd, alu_data, cyc + 1);
         long_valid = sent < 5; long_rd = 5'(20 + sent); long_data = 32'h100 + 32'(sent);
         if (long_valid && long_ready) begin
            lq.push_back('{long_rd, long_data, -1});
            sent++; acc++;
         end
         tick();
      end
      check_eq("fill_accepts", 64'(acc), 64'd4);
      check_eq("fill_ready_low", 64'(long_ready), 64'd0);
      while (lq.size() > 0) q.push_back(lq.pop_front());
      idle_inputs(); repeat (8) tick();
      check_eq("fill_ready_back", 64'(long_ready), 64'd1);
      check_eq("fill_drained", 64'(q.size()), 64'd0);
      // scoreboard set, re-issue on clear, final clear
      rs1 = 9; rs2 = 0;
      issue_valid = 1; issue_rd = 9;
      tick(); idle_inputs();
      check_eq("sb_set", 64'(rs1_busy), 64'd1);
      check_eq("sb_rs0", 64'(rs2_busy), 64'd0);
      repeat (2) tick();
      check_eq("sb_hold", 64'(rs1_busy), 64'd1);
      long_valid = 1; long_rd = 9; long_data = 32'h99;
      expect_wr(9, 32'h99, cyc + LONG_LAT);
      tick(); idle_inputs();
      issue_valid = 1; issue_rd = 9;
      tick(); idle_inputs();
      check_eq("sb_reissue", 64'(rs1_busy), 64'd1);
      repeat (2) tick();
      check_eq("sb_still", 64'(rs1_busy), 64'd1);
      long_valid = 1; long_rd = 9; long_data = 32'h98;
      expect_wr(9, 32'h98, cyc + LONG_LAT);
      tick(); idle_inputs();
`ifndef WB_BYPASS_EN
      check_eq("sb_pending", 64'(rs1_busy), 64'd1);
      tick();
`endif
      check_eq("sb_clr_wr", 64'(wb_write_enable), 64'd1);
      check_eq("sb_cleared", 64'(rs1_busy), 64'd0);
      repeat (2) tick();
      // halt drain: two queued entries plus one outstanding issue
      rs1 = 14; rs2 = 15;
      issue_valid = 1; issue_rd = 12; alu_valid = 1; alu_rd = 1; alu_data = 32'h11;
      long_valid = 1; long_rd = 12; long_data = 32'hC12;
      expect_wr(1, 32'h11, cyc + 1);
      tick();
      issue_rd = 13; alu_rd = 2; alu_data = 32'h22; long_rd = 13; long_data = 32'hC13;
      expect_wr(2, 32'h22, cyc + 1);
      tick();
      long_valid = 0; issue_rd = 14; alu_rd = 3; alu_data = 32'h33; halt_req = 1;
      expect_wr(3, 32'h33, cyc + 1);
      tick(); idle_inputs();
      expect_wr(12, 32'hC12, -1);
      expect_wr(13, 32'hC13, -1);
      issue_valid = 1; issue_rd = 15;
      tick(); idle_inputs();
      check_eq("drain_issue_ignored", 64'(rs2_busy), 64'd0);
      repeat (4) tick();
      check_eq("drain_wait", 64'(is_drained), 64'd0);
      check_eq("drain_pending", 64'(rs1_busy), 64'd1);
      long_valid = 1; long_rd = 14; long_data = 32'hC14;
      expect_wr(14, 32'hC14, -1);
      tick(); idle_inputs();
      w = 0;
      while (!is_drained && w < 20) begin
         tick();
         w++;
      end
      check_eq("drain_done", 64'(is_drained), 64'd1);
      check_eq("drain_commits", 64'(q.size()), 64'd0);
      alu_valid = 1; alu_rd = 4; alu_data = 32'h44; long_valid = 1; long_rd = 6;
      check_eq("halted_ready", 64'(long_ready), 64'd0);
      tick(); idle_inputs(); repeat (2) tick();
      check_eq("halted_hold", 64'(is_drained), 64'd1);
      // reset in the middle of a drain discards queued writes
      reset = 1; tick(); reset = 0;
      check_eq("rerun_drained", 64'(is_drained), 64'd0);
      rs1 = 20;
      issue_valid = 1; issue_rd = 20; alu_valid = 1; alu_rd = 0;
      long_valid = 1; long_rd = 20; long_data = 32'hD20; halt_req = 1;
      tick(); idle_inputs();
      alu_valid = 1; long_valid = 1; long_rd = 21; long_data = 32'hD21;
      tick(); idle_inputs();
      check_eq("mid_not_drained", 64'(is_drained), 64'd0);
      check_eq("mid_busy", 64'(rs1_busy), 64'd1);
      reset = 1; tick();
      check_eq("mid_rst_we", 64'(wb_write_enable), 64'd0);
      check_eq("mid_rst_rd", 64'(wb_rd), 64'd0);
      check_eq("mid_rst_data", 64'(wb_data), 64'd0);
      check_eq("mid_rst_ready", 64'(long_ready), 64'd1);
      check_eq("mid_rst_busy", 64'(rs1_busy), 64'd0);
      check_eq("mid_rst_drained", 64'(is_drained), 64'd0);
      reset = 0;
      repeat (4) tick();
      check_eq("post_rst_run", 64'(is_drained), 64'd0);
      check_eq("queue_empty", 64'(q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
